// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
// Bit-serial subtraction controller. A single full-subtractor cell is reused
// across the WIDTH bits of an operand pair, LSB first, with the running borrow
// held in a flop. One operation takes WIDTH cycles in RUN plus one DONE cycle.
// Back-to-back operation is possible by accepting start in the DONE cycle.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   Defined   -> ovf port present (signed overflow of a - b).
//   Undefined -> ovf port and its logic are absent.
//
// Parameters:
//   WIDTH   operand/result width, 2..32
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset, priority over start
//   start   request, accepted only in IDLE or DONE
//   a, b    minuend / subtrahend, sampled on the accepted start edge
//   bin     borrow-in, sampled on the accepted start edge
//   busy    high while an operation is in RUN
//   done    one-cycle completion strobe
//   diff    registered difference, held between operations
//   borrow  registered final borrow-out, held between operations
//   ovf     registered signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Full-subtractor cell: difference bit
  function automatic logic fs_diff(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  // Full-subtractor cell: borrow-out
  function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] sa_q,     sa_d;
  logic [WIDTH-1:0] sb_q,     sb_d;
  logic [WIDTH-1:0] sr_q,     sr_d;
  logic             br_q,     br_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             bit_d_s;
  logic             bit_bo_s;
`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out of sa/sb, so they are kept separately.
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic             ovf_q,    ovf_d;
`endif

  // Shared subtractor cell operating on the current LSBs
  always_comb begin
    bit_d_s  = fs_diff(sa_q[0], sb_q[0], br_q);
    bit_bo_s = fs_borrow(sa_q[0], sb_q[0], br_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d = {1'b0, sa_q[WIDTH-1:1]};
        sb_d = {1'b0, sb_q[WIDTH-1:1]};
        sr_d = {bit_d_s, sr_q[WIDTH-1:1]};
        br_d = bit_bo_s;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the result straight from the cell output so it
          // is valid in the DONE cycle.
          diff_d   = {bit_d_s, sr_q[WIDTH-1:1]};
          borrow_d = bit_bo_s;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d_s);
`endif
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered from the next state.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
// Directed and randomised self-checking bench for serial_sub_ctrl (WIDTH=8).
// Inputs are driven 1 time unit after the rising edge; outputs are checked at
// the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_assert  = 0;
  int n_fail    = 0;
  int done_seen = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Count done strobes mid-cycle
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One single-pulse operation with full latency/hold checks.
  task automatic op_single(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                           input logic [7:0] ed, input logic eb,
                           input logic [7:0] hd, input logic hb);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta; b = ~tb_v; bin = ~tbin;
    for (int i = 0; i < 8; i++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("diff_hold", diff, hd);
      chk("borrow_hold", borrow, hb);
      tick();
    end
    chk("done_strobe", done, 1);
    chk("busy_done", busy, 0);
    chk("diff", diff, ed);
    chk("borrow", borrow, eb);
    tick();
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("diff_idle_hold", diff, ed);
  endtask

  logic [7:0] ba [3];
  logic [7:0] bb [3];
  logic       bbin [3];
  logic [7:0] bd [3];
  logic       bbo [3];

  initial begin
    int         ds;
    int         accepts;
    logic [8:0] t;

    // Reset, with start held high to show rst wins
    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1;
    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0; start = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // 100 - 37 = 63
    op_single(8'd100, 8'd37, 1'b0, 8'h3F, 1'b0, 8'h00, 1'b0);
    // 0 - 1 underflow
    op_single(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8'h3F, 1'b0);
    // 5 - 5 - 1 underflow via borrow-in
    op_single(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Back-to-back with operands scrambled during RUN
    ba[0] = 8'h12; bb[0] = 8'h34; bbin[0] = 1'b0; bd[0] = 8'hDE; bbo[0] = 1'b1;
    ba[1] = 8'hF0; bb[1] = 8'h0F; bbin[1] = 1'b1; bd[1] = 8'hE0; bbo[1] = 1'b0;
    ba[2] = 8'h55; bb[2] = 8'h54; bbin[2] = 1'b1; bd[2] = 8'h00; bbo[2] = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = ba[k]; b = bb[k]; bin = bbin[k];
      tick();
      for (int i = 0; i < 8; i++) begin
        chk("b2b_busy", busy, 1);
        chk("b2b_done_low", done, 0);
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        tick();
      end
      chk("b2b_done", done, 1);
      chk("b2b_busy_low", busy, 0);
      chk("b2b_diff", diff, bd[k]);
      chk("b2b_borrow", borrow, bbo[k]);
    end
    start = 1'b0;
    tick();
    chk("b2b_end_done", done, 0);
    chk("b2b_end_busy", busy, 0);

    // Abort by reset in the 4th RUN cycle
    op_single(8'd100, 8'd37, 1'b0, 8'h3F, 1'b0, 8'h00, 1'b0);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy_before", busy, 1);
    chk("abort_diff_before", diff, 8'h3F);
    ds = done_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    repeat (10) tick();
    chk("abort_no_done", done_seen - ds, 0);
    chk("abort_no_resume", busy, 0);
    op_single(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    op_single(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 8'h02, 1'b0);
    chk("ovf_80_01", ovf, 1);
    op_single(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 8'h7F, 1'b0);
    chk("ovf_7F_FF", ovf, 1);
    op_single(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 8'h80, 1'b1);
    chk("ovf_10_01", ovf, 0);
`endif

    // Random sweep against a - b - bin
    ds = done_seen;
    accepts = 0;
    start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      t = {1'b0, a} - {1'b0, b} - {8'h00, bin};
      tick();
      accepts++;
      repeat (8) tick();
      chk("rnd_diff", diff, t[7:0]);
      chk("rnd_borrow", borrow, t[8]);
    end
    start = 1'b0;
    tick();
    chk("rnd_done_count", done_seen - ds, accepts);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
